// File: rtl/ram_pkg.sv
// Shared types, pattern codes and the data-pattern generator for the RAM BIST.
package ram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    DONE
  } state_t;

  localparam logic [1:0] PAT_ADDR = 2'd0;
  localparam logic [1:0] PAT_INV  = 2'd1;
  localparam logic [1:0] PAT_CHK  = 2'd2;
  localparam logic [1:0] PAT_ZERO = 2'd3;

  // Returns a 32-bit pattern word; callers size-cast it down to DATA_W.
  // Truncating the 32-bit result matches "zero-extend or truncate addr to DATA_W".
  function automatic logic [31:0] pat(input logic [1:0] pattern, input logic [31:0] addr);
    logic [31:0] r;
    case (pattern)
      PAT_ADDR: r = addr;
      PAT_INV:  r = ~addr;
      PAT_CHK:  r = addr[0] ? 32'hAAAA_AAAA : 32'h5555_5555;
      default:  r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ram_bist_master_if.sv
// RAM-side bus between the BIST master and the dual-port RAM.
interface ram_bist_master_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              valid_wr;
  logic [ADDR_W-1:0] addr_wr;
  logic [DATA_W-1:0] data_wr;
  logic              valid_rd;
  logic [ADDR_W-1:0] addr_rd;
  logic [DATA_W-1:0] data_rd;

  modport master (
    output valid_wr, addr_wr, data_wr, valid_rd, addr_rd,
    input  data_rd
  );

  modport slave (
    input  valid_wr, addr_wr, data_wr, valid_rd, addr_rd,
    output data_rd
  );
endinterface

// File: rtl/ram_bist_checker.sv
// Read-back checker: one-entry pending stage, comparator, error tracking.
module ram_bist_checker #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              issue,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic [DATA_W-1:0] issue_exp,
  input  logic [DATA_W-1:0] data_rd,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] fail_addr,
  output logic              clean_next
);

  logic              pend_valid;
  logic [ADDR_W-1:0] pend_addr;
  logic [DATA_W-1:0] pend_exp;
  logic              mismatch;

  // Compare RAM output against the expectation of the read issued last cycle.
  always_comb begin
    mismatch   = pend_valid && (data_rd != pend_exp);
    clean_next = (err_count == '0) && !mismatch;
  end

  // Pending stage tracks the read issued in the previous cycle.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      pend_exp   <= '0;
    end else begin
      pend_valid <= issue;
      pend_addr  <= issue_addr;
      pend_exp   <= issue_exp;
    end
  end

  // Saturating error count and first-failure address capture.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      err_count <= '0;
      fail_addr <= '0;
    end else if (mismatch) begin
      if (err_count != '1) err_count <= err_count + 1'b1;
      if (err_count == '0) fail_addr <= pend_addr;
    end
  end

endmodule

// File: rtl/ram_bist_master.sv
// BIST master: fills the RAM with a pattern, reads it back, reports results.
module ram_bist_master
  import ram_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic                clk,
  input  logic                rst,
  ram_bist_master_if.master   ram,
  input  logic                start,
  input  logic [1:0]          pattern,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ADDR_W:0]     err_count,
  output logic [ADDR_W-1:0]   fail_addr
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            state, state_n;
  logic [ADDR_W-1:0] cnt;
  logic [1:0]        pattern_q;
  logic [DATA_W-1:0] cur_pat;
  logic              accept;
  logic              last;
  logic              clean_next;

  assign cur_pat = DATA_W'(pat(pattern_q, 32'(cnt)));
  assign accept  = (state == IDLE) && start;
  assign last    = (cnt == LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = WRITE;
      WRITE:   if (last)  state_n = READ;
      READ:    if (last)  state_n = DRAIN;
      DRAIN:   state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Moore outputs decoded from the state register and address counter.
  always_comb begin
    ram.valid_wr = (state == WRITE);
    ram.addr_wr  = (state == WRITE) ? cnt : '0;
    ram.data_wr  = (state == WRITE) ? cur_pat : '0;
    ram.valid_rd = (state == READ);
    ram.addr_rd  = (state == READ) ? cnt : '0;
    busy         = (state != IDLE);
    done         = (state == DONE);
  end

  // Address counter, pattern latch and pass flag.
  // pass is set on the DRAIN edge from the checker's look-ahead so it is
  // already valid during the done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      pattern_q <= PAT_ADDR;
      pass      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          cnt       <= '0;
          pattern_q <= pattern;
          pass      <= 1'b0;
        end
        WRITE, READ: cnt <= last ? '0 : cnt + 1'b1;
        DRAIN:       pass <= clean_next;
        default:     ;
      endcase
    end
  end

  ram_bist_checker #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_checker (
    .clk        (clk),
    .rst        (rst),
    .clear      (accept),
    .issue      (state == READ),
    .issue_addr (cnt),
    .issue_exp  (cur_pat),
    .data_rd    (ram.data_rd),
    .err_count  (err_count),
    .fail_addr  (fail_addr),
    .clean_next (clean_next)
  );

endmodule

// File: tb/tb_ram_bist_master.sv
// Self-checking bench for ram_bist_master with a behavioural 256x8 RAM model.
module tb_ram_bist_master;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] pattern;
  logic       busy, done, pass;
  logic [8:0] err_count;
  logic [7:0] fail_addr;

  int tests = 0;
  int fails = 0;

  logic [7:0] mem   [256];
  logic [7:0] stuck [256];

  int ref_err;
  int ref_fail;
  bit ref_pass;

  ram_bist_master_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  ram_bist_master #(.ADDR_W(8), .DATA_W(8), .DEPTH(256)) dut (
    .clk       (clk),
    .rst       (rst),
    .ram       (bus),
    .start     (start),
    .pattern   (pattern),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_addr (fail_addr)
  );

  always #5 clk = ~clk;

  // RAM model: synchronous write, one-cycle read latency, stuck-at-1 masks on read.
  always @(posedge clk) begin
    if (rst) begin
      bus.data_rd <= '0;
    end else begin
      if (bus.valid_wr) mem[bus.addr_wr] <= bus.data_wr;
      if (bus.valid_rd) bus.data_rd <= mem[bus.addr_rd] | stuck[bus.addr_rd];
    end
  end

  initial begin
    #2ms;
    $display("FAIL timeout: simulation still running, want finished");
    $fatal(1, "timeout");
  end

  function automatic logic [7:0] ref_pat(input int p, input int a);
    case (p)
      0:       return 8'(a % 256);
      1:       return 8'(255 - (a % 256));
      2:       return ((a % 2) == 1) ? 8'hAA : 8'h55;
      default: return 8'h00;
    endcase
  endfunction

  task automatic clear_faults();
    for (int i = 0; i < 256; i++) stuck[i] = 8'h00;
  endtask

  task automatic compute_ref(input int p);
    logic [7:0] e;
    ref_err  = 0;
    ref_fail = 0;
    for (int a = 0; a < 256; a++) begin
      e = ref_pat(p, a);
      if ((e | stuck[a]) != e) begin
        if (ref_err == 0) ref_fail = a;
        ref_err++;
      end
    end
    ref_pass = (ref_err == 0);
  endtask

  // One full run with per-cycle strobe checks and final result checks.
  task automatic run_and_check(input int p, input bit extra, input string name);
    bit evw, evr, edone;
    logic [7:0] ed;
    compute_ref(p);
    @(negedge clk);
    start   = 1'b1;
    pattern = 2'(p);
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 514; k++) begin
      evw   = (k <= 256);
      evr   = (k >= 257) && (k <= 512);
      edone = (k == 514);
      tests++;
      if (bus.valid_wr !== evw || bus.valid_rd !== evr || done !== edone || busy !== 1'b1) begin
        fails++;
        $display("FAIL %s strobes cycle %0d: wr=%b rd=%b done=%b busy=%b, want wr=%b rd=%b done=%b busy=1",
                 name, k, bus.valid_wr, bus.valid_rd, done, busy, evw, evr, edone);
      end
      if (evw) begin
        ed = ref_pat(p, k - 1);
        tests++;
        if (bus.addr_wr !== 8'(k - 1) || bus.data_wr !== ed) begin
          fails++;
          $display("FAIL %s write cycle %0d: addr=%h data=%h, want addr=%h data=%h",
                   name, k, bus.addr_wr, bus.data_wr, 8'(k - 1), ed);
        end
      end
      if (evr) begin
        tests++;
        if (bus.addr_rd !== 8'(k - 257)) begin
          fails++;
          $display("FAIL %s read cycle %0d: addr=%h, want %h", name, k, bus.addr_rd, 8'(k - 257));
        end
      end
      if (p == 1 && k == 17) begin
        tests++;
        if (bus.data_wr !== 8'hEF) begin
          fails++;
          $display("FAIL %s inv_0x10: data=%h, want ef", name, bus.data_wr);
        end
      end
      if (edone) begin
        tests++;
        if (pass !== ref_pass || err_count !== 9'(ref_err) || fail_addr !== 8'(ref_fail)) begin
          fails++;
          $display("FAIL %s result at done: pass=%b err=%0d fail=%h, want pass=%b err=%0d fail=%h",
                   name, pass, err_count, fail_addr, ref_pass, ref_err, 8'(ref_fail));
        end
      end
      start = extra && (k == 50 || k == 300);
      @(negedge clk);
    end
    start = 1'b0;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || pass !== ref_pass ||
        err_count !== 9'(ref_err) || fail_addr !== 8'(ref_fail)) begin
      fails++;
      $display("FAIL %s after done: busy=%b done=%b pass=%b err=%0d fail=%h, want busy=0 done=0 pass=%b err=%0d fail=%h",
               name, busy, done, pass, err_count, fail_addr, ref_pass, ref_err, 8'(ref_fail));
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    pattern = 2'd0;
    repeat (3) @(negedge clk);
    tests++;
    if (bus.valid_wr !== 1'b0 || bus.valid_rd !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        pass !== 1'b0 || bus.addr_wr !== 8'h00 || bus.addr_rd !== 8'h00 || bus.data_wr !== 8'h00 ||
        err_count !== 9'd0 || fail_addr !== 8'h00) begin
      fails++;
      $display("FAIL reset_values: wr=%b rd=%b busy=%b done=%b pass=%b aw=%h ar=%h dw=%h err=%0d fail=%h, want all 0",
               bus.valid_wr, bus.valid_rd, busy, done, pass, bus.addr_wr, bus.addr_rd, bus.data_wr, err_count, fail_addr);
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset: busy=%b, want 0", busy);
    end
  endtask

  task automatic test_patterns();
    clear_faults();
    run_and_check(0, 1'b0, "pat_addr");
    tests++;
    if (pass !== 1'b1 || err_count !== 9'd0 || fail_addr !== 8'h00) begin
      fails++;
      $display("FAIL pat_addr_const: pass=%b err=%0d fail=%h, want 1 0 00", pass, err_count, fail_addr);
    end
    run_and_check(1, 1'b0, "pat_inv");
    tests++;
    if (pass !== 1'b1) begin
      fails++;
      $display("FAIL pat_inv_const: pass=%b, want 1", pass);
    end
    stuck[8'h2A] = 8'h08;
    run_and_check(2, 1'b0, "pat_chk");
    tests++;
    if (pass !== 1'b0 || err_count !== 9'd1 || fail_addr !== 8'h2A) begin
      fails++;
      $display("FAIL pat_chk_const: pass=%b err=%0d fail=%h, want 0 1 2a", pass, err_count, fail_addr);
    end
    clear_faults();
    stuck[8'h05] = 8'h01;
    stuck[8'h80] = 8'h40;
    run_and_check(3, 1'b0, "pat_zero");
    tests++;
    if (pass !== 1'b0 || err_count !== 9'd2 || fail_addr !== 8'h05) begin
      fails++;
      $display("FAIL pat_zero_const: pass=%b err=%0d fail=%h, want 0 2 05", pass, err_count, fail_addr);
    end
    clear_faults();
  endtask

  task automatic test_random();
    int p, n;
    for (int r = 0; r < 4; r++) begin
      clear_faults();
      p = int'($urandom_range(0, 3));
      n = int'($urandom_range(0, 4));
      for (int f = 0; f < n; f++)
        stuck[$urandom_range(0, 255)] |= 8'($urandom_range(1, 255));
      run_and_check(p, 1'b0, "random");
    end
    clear_faults();
  endtask

  // Starts the run and advances to the negedge inside the given cycle number.
  task automatic launch_to_cycle(input int p, input int cyc);
    @(negedge clk);
    start   = 1'b1;
    pattern = 2'(p);
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k < cyc; k++) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    clear_faults();
    launch_to_cycle(0, 100);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if (bus.valid_wr !== 1'b0 || busy !== 1'b0 || err_count !== 9'd0) begin
      fails++;
      $display("FAIL reset_in_write: wr=%b busy=%b err=%0d, want 0 0 0", bus.valid_wr, busy, err_count);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++;
      if (bus.valid_wr !== 1'b0 || bus.valid_rd !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL quiet_after_reset %0d: wr=%b rd=%b busy=%b, want 0 0 0", i, bus.valid_wr, bus.valid_rd, busy);
      end
    end
    stuck[8'h10] = 8'h01;
    launch_to_cycle(0, 300);
    tests++;
    if (err_count !== 9'd1 || fail_addr !== 8'h10) begin
      fails++;
      $display("FAIL err_before_reset: err=%0d fail=%h, want 1 10", err_count, fail_addr);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if (bus.valid_rd !== 1'b0 || busy !== 1'b0 || err_count !== 9'd0 || fail_addr !== 8'h00 || pass !== 1'b0) begin
      fails++;
      $display("FAIL reset_in_read: rd=%b busy=%b err=%0d fail=%h pass=%b, want 0 0 0 00 0",
               bus.valid_rd, busy, err_count, fail_addr, pass);
    end
    clear_faults();
    run_and_check(0, 1'b0, "after_reset");
  endtask

  task automatic test_start_ignored();
    clear_faults();
    run_and_check(2, 1'b1, "start_ignored");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        fails++;
        $display("FAIL no_relaunch %0d: busy=%b done=%b, want 0 0", i, busy, done);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit edone;
    int ndone;
    clear_faults();
    ndone = 0;
    @(negedge clk);
    start   = 1'b1;
    pattern = 2'd1;
    @(negedge clk);
    for (int k = 1; k <= 1035; k++) begin
      edone = (k == 514) || (k == 1029);
      if (done === 1'b1) ndone++;
      tests++;
      if (done !== edone) begin
        fails++;
        $display("FAIL b2b_done cycle %0d: done=%b, want %b", k, done, edone);
      end
      if (k == 515) begin
        tests++;
        if (busy !== 1'b0) begin
          fails++;
          $display("FAIL b2b_idle_gap: busy=%b, want 0", busy);
        end
      end
      if (k == 516) begin
        tests++;
        if (bus.valid_wr !== 1'b1 || bus.addr_wr !== 8'h00 || bus.data_wr !== 8'hFF) begin
          fails++;
          $display("FAIL b2b_relaunch: wr=%b addr=%h data=%h, want 1 00 ff", bus.valid_wr, bus.addr_wr, bus.data_wr);
        end
      end
      if (k == 1029) start = 1'b0;
      @(negedge clk);
    end
    tests++;
    if (ndone != 2 || busy !== 1'b0) begin
      fails++;
      $display("FAIL b2b_count: dones=%0d busy=%b, want 2 0", ndone, busy);
    end
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    pattern = 2'd0;
    clear_faults();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    test_reset();
    test_patterns();
    test_random();
    test_reset_mid();
    test_start_ignored();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
